// File: rtl/config_bitstream_loader.sv
// Configuration bitstream loader: serialises TOTAL_BITS of byte-wide configuration
// data MSB first into a connection-box shift chain and supervises chain completion.
module config_bitstream_loader #(
  parameter int TOTAL_BITS   = 96,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       bit_out,
  output logic       prgm_b,
  output logic       cb_prgm_b,
  output logic       cb_prgm_b_in,
  input  logic       chain_done,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [15:0] NUM_BYTES    = 16'(TOTAL_BITS / 8);
  localparam logic [15:0] LAST_BIT     = 16'(TOTAL_BITS - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);

  state_t      state_r, state_next_s;
  logic [7:0]  sh_r, sh_next_s;
  logic [3:0]  occ_r, occ_next_s;
  logic [15:0] bit_cnt_r, bit_cnt_next_s;
  logic [15:0] byte_cnt_r, byte_cnt_next_s;
  logic [15:0] to_cnt_r, to_cnt_next_s;

  logic byte_ready_r, cb_prgm_b_r, prgm_b_r, cb_prgm_b_in_r, busy_r, done_r, error_r;
  logic byte_ready_s, cb_prgm_b_s, prgm_b_s, cb_prgm_b_in_s, busy_s, done_s, error_s;

  logic shift_s, accept_s, restart_s;

  // A valid bit is on bit_out whenever the shift register holds any bits
  assign shift_s   = (state_r == ST_LOAD) && (occ_r != 4'd0);
  assign accept_s  = byte_valid && byte_ready_r;
  assign restart_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; chain_done wins over the timeout in WAIT
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_next_s = ST_LOAD;
        else       state_next_s = state_r;
      end
      ST_LOAD: begin
        if (chain_done)                           state_next_s = ST_ERROR;
        else if (shift_s && bit_cnt_r == LAST_BIT) state_next_s = ST_WAIT;
        else                                       state_next_s = ST_LOAD;
      end
      ST_WAIT: begin
        if (chain_done)                   state_next_s = ST_DONE;
        else if (to_cnt_r == TIMEOUT_LAST) state_next_s = ST_ERROR;
        else                               state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath next values: byte load, shift, stall-hold and counters
  always_comb begin
    sh_next_s       = sh_r;
    occ_next_s      = occ_r;
    bit_cnt_next_s  = bit_cnt_r;
    byte_cnt_next_s = byte_cnt_r;
    to_cnt_next_s   = to_cnt_r;
    if (restart_s) begin
      sh_next_s       = 8'h00;
      occ_next_s      = 4'd0;
      bit_cnt_next_s  = 16'd0;
      byte_cnt_next_s = 16'd0;
      to_cnt_next_s   = 16'd0;
    end else if (state_r == ST_LOAD) begin
      if (state_next_s != ST_LOAD) begin
        sh_next_s  = 8'h00;
        occ_next_s = 4'd0;
      end else if (accept_s) begin
        sh_next_s  = byte_in;
        occ_next_s = 4'd8;
      end else if (shift_s) begin
        // the final bit of a byte stays on bit_out through any stall
        sh_next_s  = (occ_r == 4'd1) ? sh_r : {sh_r[6:0], 1'b0};
        occ_next_s = occ_r - 4'd1;
      end else begin
        sh_next_s  = sh_r;
        occ_next_s = occ_r;
      end
      if (shift_s) bit_cnt_next_s = bit_cnt_r + 16'd1;
      else         bit_cnt_next_s = bit_cnt_r;
      if (accept_s) byte_cnt_next_s = byte_cnt_r + 16'd1;
      else          byte_cnt_next_s = byte_cnt_r;
    end else if (state_r == ST_WAIT) begin
      if (chain_done) to_cnt_next_s = to_cnt_r;
      else            to_cnt_next_s = to_cnt_r + 16'd1;
    end else begin
      to_cnt_next_s = to_cnt_r;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_r       <= 8'h00;
      occ_r      <= 4'd0;
      bit_cnt_r  <= 16'd0;
      byte_cnt_r <= 16'd0;
      to_cnt_r   <= 16'd0;
    end else begin
      sh_r       <= sh_next_s;
      occ_r      <= occ_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      byte_cnt_r <= byte_cnt_next_s;
      to_cnt_r   <= to_cnt_next_s;
    end
  end

  // Output decode from the upcoming state so the outputs can be registered
  always_comb begin
    byte_ready_s   = 1'b0;
    cb_prgm_b_s    = 1'b0;
    prgm_b_s       = 1'b1;
    cb_prgm_b_in_s = 1'b0;
    busy_s         = 1'b0;
    done_s         = 1'b0;
    error_s        = 1'b0;
    case (state_next_s)
      ST_LOAD: begin
        prgm_b_s       = 1'b0;
        cb_prgm_b_in_s = 1'b1;
        busy_s         = 1'b1;
        cb_prgm_b_s    = (occ_next_s != 4'd0);
        byte_ready_s   = (occ_next_s <= 4'd1) && (byte_cnt_next_s < NUM_BYTES);
      end
      ST_WAIT: begin
        prgm_b_s       = 1'b0;
        cb_prgm_b_in_s = 1'b1;
        busy_s         = 1'b1;
      end
      ST_DONE:  done_s  = 1'b1;
      ST_ERROR: error_s = 1'b1;
      default:  prgm_b_s = 1'b1;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_ready_r   <= 1'b0;
      cb_prgm_b_r    <= 1'b0;
      prgm_b_r       <= 1'b1;
      cb_prgm_b_in_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
    end else begin
      byte_ready_r   <= byte_ready_s;
      cb_prgm_b_r    <= cb_prgm_b_s;
      prgm_b_r       <= prgm_b_s;
      cb_prgm_b_in_r <= cb_prgm_b_in_s;
      busy_r         <= busy_s;
      done_r         <= done_s;
      error_r        <= error_s;
    end
  end

  assign byte_ready   = byte_ready_r;
  assign bit_out      = sh_r[7];
  assign cb_prgm_b    = cb_prgm_b_r;
  assign prgm_b       = prgm_b_r;
  assign cb_prgm_b_in = cb_prgm_b_in_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;

endmodule

// File: tb/tb_config_bitstream_loader.sv
// Bench for config_bitstream_loader: a queue-of-bits model predicts every output each
// cycle, and directed scenarios pin timing and data with literal expectations.
module tb_config_bitstream_loader;
  localparam int TOTAL_BITS   = 96;
  localparam int DONE_TIMEOUT = 16;
  localparam int NB           = TOTAL_BITS / 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       chain_done = 1'b0;
  logic       byte_ready, bit_out, prgm_b, cb_prgm_b, cb_prgm_b_in, busy, done, error;

  config_bitstream_loader #(.TOTAL_BITS(TOTAL_BITS), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .bit_out(bit_out), .prgm_b(prgm_b), .cb_prgm_b(cb_prgm_b),
    .cb_prgm_b_in(cb_prgm_b_in), .chain_done(chain_done), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit seen[$];
  int shift_cyc[$];
  logic [7:0] data [NB];

  // Model: load phase plus a queue of bits still to be shifted out
  typedef enum int {P_IDLE, P_LOAD, P_WAIT, P_DONE, P_ERR} phase_t;
  phase_t m_phase = P_IDLE;
  bit     q[$];
  int     m_acc = 0, m_shifted = 0, m_wait = 0;
  bit     m_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; q.delete(); m_acc = 0; m_shifted = 0; m_wait = 0; m_last = 1'b0;
  endtask

  task automatic model_step();
    bit rdy, shifting;
    if (reset) begin
      model_reset();
    end else begin
      case (m_phase)
        P_IDLE, P_DONE, P_ERR: if (start) begin
          model_reset();
          m_phase = P_LOAD;
        end
        P_LOAD: begin
          rdy      = (q.size() <= 1) && (m_acc < NB);
          shifting = (q.size() > 0);
          if (shifting) begin m_last = q.pop_front(); m_shifted++; end
          if (byte_valid && rdy) begin
            for (int b = 7; b >= 0; b--) q.push_back(byte_in[b]);
            m_acc++;
          end
          if (chain_done) begin m_phase = P_ERR; q.delete(); end
          else if (m_shifted == TOTAL_BITS) begin m_phase = P_WAIT; m_wait = 0; end
        end
        P_WAIT: begin
          if (chain_done) m_phase = P_DONE;
          else begin
            m_wait++;
            if (m_wait == DONE_TIMEOUT) m_phase = P_ERR;
          end
        end
        default: model_reset();
      endcase
    end
  endtask

  task automatic compare_cycle();
    bit ld, act;
    ld  = (m_phase == P_LOAD);
    act = ld || (m_phase == P_WAIT);
    check("busy", busy, act);
    check("prgm_b", prgm_b, !act);
    check("cb_prgm_b_in", cb_prgm_b_in, act);
    check("cb_prgm_b", cb_prgm_b, ld && (q.size() > 0));
    check("byte_ready", byte_ready, ld && (q.size() <= 1) && (m_acc < NB));
    check("bit_out", bit_out, ld ? ((q.size() > 0) ? q[0] : m_last) : 1'b0);
    check("done", done, m_phase == P_DONE);
    check("error", error, m_phase == P_ERR);
    if (cb_prgm_b) begin seen.push_back(bit_out); shift_cyc.push_back(cyc); end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Feed bytes until stop_at shift cycles have been seen; optional gap and start pulse
  task automatic stream(input int stop_at, input bit gap, input int pulse_at);
    int base = seen.size();
    int idx = 0, hold = 0;
    bit gap_done = 1'b0, pulsed = 1'b0, acc;
    for (int n = 0; n < 400; n++) begin
      if (seen.size() - base >= stop_at) break;
      start = 1'b0;
      if (pulse_at >= 0 && !pulsed && (seen.size() - base) >= pulse_at) begin
        start = 1'b1; pulsed = 1'b1;
      end
      if (gap && !gap_done && idx == 4 && byte_ready) begin hold = 3; gap_done = 1'b1; end
      if (hold > 0) begin byte_valid = 1'b0; hold--; end
      else if (idx < NB) begin byte_valid = 1'b1; byte_in = data[idx]; end
      else byte_valid = 1'b0;
      acc = byte_valid && byte_ready;
      tick();
      if (acc) idx++;
    end
    start = 1'b0;
    byte_valid = 1'b0;
    check("stream_shift_count", seen.size() - base, stop_at);
  endtask

  task automatic check_bytes(input int base);
    logic [7:0] b;
    if (seen.size() >= base + TOTAL_BITS) begin
      for (int j = 0; j < NB; j++) begin
        for (int k = 0; k < 8; k++) b[7-k] = seen[base + 8*j + k];
        check("byte_order", b, data[j]);
      end
    end else begin
      check("bits_recorded", seen.size() - base, TOTAL_BITS);
    end
  endtask

  task automatic check_span(input int base, input int exp);
    if (seen.size() >= base + TOTAL_BITS)
      check("shift_span", shift_cyc[base + TOTAL_BITS - 1] - shift_cyc[base] + 1, exp);
    else
      check("span_bits", seen.size() - base, TOTAL_BITS);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_prgm_b"}, prgm_b, 1'b1);
    check({tag, "_cb_prgm_b"}, cb_prgm_b, 1'b0);
    check({tag, "_cb_prgm_b_in"}, cb_prgm_b_in, 1'b0);
    check({tag, "_bit_out"}, bit_out, 1'b0);
    check({tag, "_byte_ready"}, byte_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
  endtask

  task automatic begin_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", busy, 1'b1);
    check("load_prgm_b", prgm_b, 1'b0);
  endtask

  task automatic finish_done();
    chain_done = 1'b1;
    tick();
    chain_done = 1'b0;
    check("fin_done", done, 1'b1);
    check("fin_prgm_b", prgm_b, 1'b1);
    check("fin_error", error, 1'b0);
  endtask

  initial begin
    int base;
    for (int i = 0; i < NB; i++) data[i] = 8'hA5 + 8'(i);
    tick(); tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Continuous stream of 12 bytes, chain_done two cycles after the last bit
    base = seen.size();
    begin_load();
    check("first_ready", byte_ready, 1'b1);
    stream(TOTAL_BITS, 1'b0, -1);
    check("wait_busy", busy, 1'b1);
    check("wait_cb", cb_prgm_b, 1'b0);
    check("first_byte", {seen[base], seen[base+1], seen[base+2], seen[base+3],
                         seen[base+4], seen[base+5], seen[base+6], seen[base+7]}, 8'b10100101);
    check_bytes(base);
    check_span(base, 96);
    tick();
    finish_done();
    tick();
    check("done_sticky", done, 1'b1);

    // Three-cycle byte_valid gap after byte 4
    base = seen.size();
    begin_load();
    check("done_cleared", done, 1'b0);
    stream(TOTAL_BITS, 1'b1, -1);
    check_bytes(base);
    check_span(base, 99);
    finish_done();

    // No chain_done: error exactly 16 cycles after entering WAIT_DONE
    begin_load();
    stream(TOTAL_BITS, 1'b0, -1);
    for (int k = 1; k <= DONE_TIMEOUT; k++) begin
      tick();
      if (k == DONE_TIMEOUT - 1) check("timeout_early", error, 1'b0);
    end
    check("timeout_error", error, 1'b1);
    check("timeout_done", done, 1'b0);

    // chain_done during LOAD after 50 bits
    begin_load();
    check("error_cleared", error, 1'b0);
    stream(50, 1'b0, -1);
    chain_done = 1'b1;
    tick();
    chain_done = 1'b0;
    check("early_error", error, 1'b1);
    check("early_ready", byte_ready, 1'b0);
    check("early_busy", busy, 1'b0);

    // start pulsed mid-LOAD is ignored
    base = seen.size();
    begin_load();
    stream(TOTAL_BITS, 1'b0, 30);
    check_bytes(base);
    check_span(base, 96);
    finish_done();

    // Asynchronous reset after 40 bits, then a clean reload
    begin_load();
    stream(40, 1'b0, -1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_idle_outputs("async_reset");
    tick();
    reset = 1'b0;
    tick();
    base = seen.size();
    begin_load();
    stream(TOTAL_BITS, 1'b0, -1);
    check_bytes(base);
    finish_done();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
